// File: rtl/sand_brush_painter.sv
// Brush rasteriser for the falling-sand grid: walks a circular footprint around
// a latched centre and issues one req/gnt memory write per in-bounds cell.
module sand_brush_painter #(
  parameter int GRID_W = 640,
  parameter int GRID_H = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [10:0]       brush_x,
  input  logic [9:0]        brush_y,
  input  logic [1:0]        brush_r,
  input  logic [1:0]        brush_t,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_data,
  input  logic              mem_gnt,
  output logic [1:0]        dbg_state
);

  // Memory port handshake: mem_req stays high with mem_addr/mem_data frozen
  // until the arbiter returns mem_gnt; a write happens on every req & gnt cycle.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_REQ  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [10:0]       x_q;
  logic [9:0]        y_q;
  logic [1:0]        r_q;
  logic [1:0]        t_q;
  logic signed [2:0] dx_q, dy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        data_q;

  logic signed [2:0]  r_s;
  logic signed [2:0]  r_in_neg;
  logic               at_last;
  logic signed [2:0]  dx_nxt, dy_nxt;
  logic [2:0]         adx, ady;
  logic [4:0]         sq_sum, sq_lim;
  logic               in_mask;
  logic signed [11:0] cx, cy;
  logic               in_x, in_y, qualify;
  logic [ADDR_W-1:0]  addr_calc;

  // ---------------------------------------------------------------- datapath
  always_comb begin
    r_s      = signed'({1'b0, r_q});
    r_in_neg = -signed'({1'b0, brush_r});
    at_last  = (dx_q == r_s) && (dy_q == r_s);

    if (dx_q == r_s) begin
      dx_nxt = -r_s;
      dy_nxt = dy_q + 3'sd1;
    end else begin
      dx_nxt = dx_q + 3'sd1;
      dy_nxt = dy_q;
    end

    // |offset| is at most 3, so squares and the r*r+r limit fit in 5 bits.
    adx     = dx_q[2] ? 3'(-dx_q) : 3'(dx_q);
    ady     = dy_q[2] ? 3'(-dy_q) : 3'(dy_q);
    sq_sum  = ({2'b00, adx} * {2'b00, adx}) + ({2'b00, ady} * {2'b00, ady});
    sq_lim  = ({3'b000, r_q} * {3'b000, r_q}) + {3'b000, r_q};
    in_mask = (sq_sum <= sq_lim);

    // 12-bit signed cell coordinates so x-3 / y-3 go negative instead of wrapping.
    cx   = signed'({1'b0, x_q}) + {{9{dx_q[2]}}, dx_q};
    cy   = signed'({2'b00, y_q}) + {{9{dy_q[2]}}, dy_q};
    in_x = !cx[11] && ($unsigned(cx) < 12'(GRID_W));
    in_y = !cy[11] && ($unsigned(cy) < 12'(GRID_H));

    qualify   = in_mask && in_x && in_y;
    addr_calc = ADDR_W'($unsigned(cy)) * ADDR_W'(GRID_W) + ADDR_W'($unsigned(cx));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      r_q    <= '0;
      t_q    <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q  <= brush_x;
            y_q  <= brush_y;
            r_q  <= brush_r;
            t_q  <= brush_t;
            dx_q <= r_in_neg;
            dy_q <= r_in_neg;
          end
        end
        S_SCAN: begin
          if (qualify) begin
            addr_q <= addr_calc;
            data_q <= t_q;
          end else if (!at_last) begin
            dx_q <= dx_nxt;
            dy_q <= dy_nxt;
          end
        end
        S_REQ: begin
          // The offset only moves on grant, so a stalled request stays put.
          if (mem_gnt && !at_last) begin
            dx_q <= dx_nxt;
            dy_q <= dy_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_SCAN;
      S_SCAN: begin
        if (qualify)      state_d = S_REQ;
        else if (at_last) state_d = S_DONE;
      end
      S_REQ: begin
        if (mem_gnt) state_d = at_last ? S_DONE : S_SCAN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    mem_req   = (state_q == S_REQ);
    mem_addr  = addr_q;
    mem_data  = data_q;
    dbg_state = state_q;
  end

endmodule
